pipeline_hazard_ctrl: RTL and testbench

Central stall/flush controller for the 5-stage MIPS pipeline. It drives the write enables and flush/bubble controls of PC, IF/ID, ID/EX, EX/MEM and MEM/WB. It resolves three conditions: load-use hazards, branch/jump redirects resolved in EX/MEM, and multi-cycle data-memory waits. It also keeps saturating stall and flush statistics for debug.

---
 rtl/pipeline_hazard_ctrl.sv | 147 ++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for a 5-stage MIPS pipeline: load-use stalls,
// EX/MEM branch/jump redirects, multi-cycle data-memory waits, debug statistics.
module pipeline_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       ifid_rs,
  input  logic [4:0]       ifid_rt,
  input  logic             idex_memread,
  input  logic [4:0]       idex_rt,
  input  logic             exmem_branch,
  input  logic             exmem_zf,
  input  logic             exmem_jump,
  input  logic             exmem_memread,
  input  logic             exmem_memwrite,
  input  logic             dmem_ready,
  output logic             pc_write,
  output logic             pc_redirect,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_write,
  output logic             exmem_flush,
  output logic             memwb_bubble,
  output logic             dmem_req,
  output logic             mem_error,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count,
  output logic             dbg_state
);

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  localparam logic [7:0]       TMO     = 8'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state_q, state_d;
  logic [7:0]       wait_cnt_q, wait_cnt_d;
  logic             mem_error_q, mem_error_d;
  logic [CNT_W-1:0] stall_q, flush_q;

  logic memop, taken, lu;
  logic freeze, resolve;

  assign memop = exmem_memread | exmem_memwrite;
  assign taken = (exmem_branch & exmem_zf) | exmem_jump;
  assign lu    = idex_memread && (idex_rt != 5'd0) &&
                 ((idex_rt == ifid_rs) || (idex_rt == ifid_rt));

  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    mem_error_d  = mem_error_q;
    freeze       = 1'b0;
    resolve      = 1'b0;
    pc_write     = 1'b1;
    pc_redirect  = 1'b0;
    ifid_write   = 1'b1;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    exmem_write  = 1'b1;
    exmem_flush  = 1'b0;
    memwb_bubble = 1'b0;
    dmem_req     = 1'b0;

    if (!rst) begin
      unique case (state_q)
        RUN: begin
          dmem_req = memop;
          if (memop && !dmem_ready) begin
            freeze     = 1'b1;
            state_d    = MEM_WAIT;
            wait_cnt_d = 8'd1;
          end else begin
            resolve = 1'b1;
          end
        end
        MEM_WAIT: begin
          dmem_req = 1'b1;
          if (!dmem_ready && (wait_cnt_q < TMO)) begin
            freeze     = 1'b1;
            wait_cnt_d = wait_cnt_q + 8'd1;
          end else begin
            // Either the access completed or it is abandoned; both release.
            if (!dmem_ready) mem_error_d = 1'b1;
            state_d    = RUN;
            wait_cnt_d = 8'd0;
            resolve    = 1'b1;
          end
        end
        default: state_d = RUN;
      endcase

      if (freeze) begin
        pc_write     = 1'b0;
        ifid_write   = 1'b0;
        exmem_write  = 1'b0;
        memwb_bubble = 1'b1;
      end else if (resolve && taken) begin
        // The redirect squashes any load-use consumer, so no stall here.
        pc_redirect = 1'b1;
        ifid_flush  = 1'b1;
        idex_flush  = 1'b1;
        exmem_flush = 1'b1;
      end else if (resolve && lu) begin
        pc_write   = 1'b0;
        ifid_write = 1'b0;
        idex_flush = 1'b1;
      end
    end else begin
      pc_write     = 1'b0;
      ifid_write   = 1'b0;
      exmem_write  = 1'b0;
      ifid_flush   = 1'b1;
      idex_flush   = 1'b1;
      exmem_flush  = 1'b1;
      memwb_bubble = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      wait_cnt_q  <= 8'd0;
      mem_error_q <= 1'b0;
      stall_q     <= '0;
      flush_q     <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      mem_error_q <= mem_error_d;
      if (!pc_write && (stall_q != CNT_MAX)) stall_q <= stall_q + 1'b1;
      if (pc_redirect && (flush_q != CNT_MAX)) flush_q <= flush_q + 1'b1;
    end
  end

  assign mem_error    = mem_error_q;
  assign stall_cycles = stall_q;
  assign flush_count  = flush_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: reset, load-use, redirects,
// memory waits, timeout, reset mid-wait and counter saturation.
module tb_pipeline_hazard_ctrl;

  localparam int CNT_W = 4;

  // Control vector order:
  // {pc_write, pc_redirect, ifid_write, ifid_flush, idex_flush,
  //  exmem_write, exmem_flush, memwb_bubble, dmem_req}
  localparam logic [8:0] C_RESET  = 9'b000110110;
  localparam logic [8:0] C_NORM   = 9'b101001000;
  localparam logic [8:0] C_NORMRQ = 9'b101001001;
  localparam logic [8:0] C_LU     = 9'b000011000;
  localparam logic [8:0] C_REDIR  = 9'b111111100;
  localparam logic [8:0] C_REDRQ  = 9'b111111101;
  localparam logic [8:0] C_FREEZE = 9'b000000011;

  logic clk, rst;
  logic [4:0] ifid_rs, ifid_rt, idex_rt;
  logic idex_memread, exmem_branch, exmem_zf, exmem_jump;
  logic exmem_memread, exmem_memwrite, dmem_ready;
  logic pc_write, pc_redirect, ifid_write, ifid_flush, idex_flush;
  logic exmem_write, exmem_flush, memwb_bubble, dmem_req, mem_error;
  logic [CNT_W-1:0] stall_cycles, flush_count;
  logic dbg_state;
  logic [8:0] ctrl;

  int n_assert = 0;
  int n_fail   = 0;

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
    .idex_memread(idex_memread), .idex_rt(idex_rt),
    .exmem_branch(exmem_branch), .exmem_zf(exmem_zf), .exmem_jump(exmem_jump),
    .exmem_memread(exmem_memread), .exmem_memwrite(exmem_memwrite),
    .dmem_ready(dmem_ready),
    .pc_write(pc_write), .pc_redirect(pc_redirect),
    .ifid_write(ifid_write), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .exmem_write(exmem_write), .exmem_flush(exmem_flush),
    .memwb_bubble(memwb_bubble), .dmem_req(dmem_req), .mem_error(mem_error),
    .stall_cycles(stall_cycles), .flush_count(flush_count),
    .dbg_state(dbg_state)
  );

  assign ctrl = {pc_write, pc_redirect, ifid_write, ifid_flush, idex_flush,
                 exmem_write, exmem_flush, memwb_bubble, dmem_req};

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ifid_rs = 5'd0; ifid_rt = 5'd0; idex_rt = 5'd0; idex_memread = 1'b0;
    exmem_branch = 1'b0; exmem_zf = 1'b0; exmem_jump = 1'b0;
    exmem_memread = 1'b0; exmem_memwrite = 1'b0; dmem_ready = 1'b1;
  endtask

  task automatic set_lu(input logic [4:0] rt, input logic [4:0] rs, input logic [4:0] rt2);
    idex_memread = 1'b1; idex_rt = rt; ifid_rs = rs; ifid_rt = rt2;
  endtask

  // Checker
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;

    // Reset held 2 cycles with taken and load-use active
    exmem_branch = 1'b1; exmem_zf = 1'b1; set_lu(5'd8, 5'd8, 5'd0);
    #1;
    chk("reset_ctrl_c0", 32'(ctrl), 32'(C_RESET));
    tick();
    chk("reset_ctrl_c1", 32'(ctrl), 32'(C_RESET));
    tick();
    rst = 1'b0; clear_inputs(); #1;
    chk("reset_stall", 32'(stall_cycles), 0);
    chk("reset_flush", 32'(flush_count), 0);
    chk("reset_err", 32'(mem_error), 0);
    chk("reset_state", 32'(dbg_state), 0);
    chk("idle_ctrl", 32'(ctrl), 32'(C_NORM));

    // Load-use on rs, one cycle then the load moves on
    tick(); set_lu(5'd8, 5'd8, 5'd3); #1;
    chk("lu_rs_ctrl", 32'(ctrl), 32'(C_LU));
    tick(); idex_memread = 1'b0; #1;
    chk("lu_after_ctrl", 32'(ctrl), 32'(C_NORM));
    chk("lu_stall1", 32'(stall_cycles), 1);
    // Load-use via rt match
    set_lu(5'd17, 5'd2, 5'd17); #1;
    chk("lu_rt_ctrl", 32'(ctrl), 32'(C_LU));
    tick(); clear_inputs();
    // $0 destination never stalls
    set_lu(5'd0, 5'd0, 5'd0); #1;
    chk("lu_r0_ctrl", 32'(ctrl), 32'(C_NORM));
    tick(); clear_inputs(); #1;
    chk("lu_stall2", 32'(stall_cycles), 2);

    // Branch taken with load-use also true: redirect wins
    exmem_branch = 1'b1; exmem_zf = 1'b1; set_lu(5'd8, 5'd8, 5'd0); #1;
    chk("br_taken_ctrl", 32'(ctrl), 32'(C_REDIR));
    tick(); clear_inputs(); #1;
    chk("br_flush1", 32'(flush_count), 1);
    chk("br_stall_keep", 32'(stall_cycles), 2);
    exmem_branch = 1'b1; exmem_zf = 1'b0; #1;
    chk("br_nt_ctrl", 32'(ctrl), 32'(C_NORM));
    tick(); clear_inputs(); exmem_jump = 1'b1; #1;
    chk("jump_ctrl", 32'(ctrl), 32'(C_REDIR));
    tick(); clear_inputs(); #1;
    chk("jump_flush2", 32'(flush_count), 2);

    // Memory wait: ready low 3 cycles, high on the 4th
    exmem_memread = 1'b1; dmem_ready = 1'b0; #1;
    chk("mw_c1_ctrl", 32'(ctrl), 32'(C_FREEZE));
    chk("mw_c1_state", 32'(dbg_state), 0);
    tick();
    chk("mw_c2_ctrl", 32'(ctrl), 32'(C_FREEZE));
    chk("mw_c2_state", 32'(dbg_state), 1);
    tick();
    chk("mw_c3_ctrl", 32'(ctrl), 32'(C_FREEZE));
    tick(); dmem_ready = 1'b1; #1;
    chk("mw_release_ctrl", 32'(ctrl), 32'(C_NORMRQ));
    tick(); clear_inputs(); #1;
    chk("mw_state_run", 32'(dbg_state), 0);
    chk("mw_stall5", 32'(stall_cycles), 5);
    chk("mw_no_err", 32'(mem_error), 0);

    // Timeout with MEM_TIMEOUT=4: 4 frozen cycles, then abandon
    exmem_memwrite = 1'b1; dmem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("to_freeze_%0d", i), 32'(ctrl), 32'(C_FREEZE));
      tick();
    end
    chk("to_release_ctrl", 32'(ctrl), 32'(C_NORMRQ));
    chk("to_err_pre", 32'(mem_error), 0);
    tick(); clear_inputs(); #1;
    chk("to_err_set", 32'(mem_error), 1);
    chk("to_state_run", 32'(dbg_state), 0);
    chk("to_stall9", 32'(stall_cycles), 9);
    tick(); tick(); #1;
    chk("to_err_sticky", 32'(mem_error), 1);

    // Freeze outranks a taken branch; redirect fires on release
    exmem_memread = 1'b1; dmem_ready = 1'b0; exmem_branch = 1'b1; exmem_zf = 1'b1; #1;
    chk("frz_over_br", 32'(ctrl), 32'(C_FREEZE));
    tick(); dmem_ready = 1'b1; #1;
    chk("rel_redirect", 32'(ctrl), 32'(C_REDRQ));
    tick(); clear_inputs(); #1;
    chk("rel_flush3", 32'(flush_count), 3);
    chk("rel_stall10", 32'(stall_cycles), 10);

    // Reset during MEM_WAIT
    exmem_memread = 1'b1; dmem_ready = 1'b0;
    tick(); #1;
    chk("rmw_state_wait", 32'(dbg_state), 1);
    rst = 1'b1; #1;
    chk("rmw_ctrl", 32'(ctrl), 32'(C_RESET));
    tick(); rst = 1'b0; clear_inputs(); #1;
    chk("rmw_state_run", 32'(dbg_state), 0);
    chk("rmw_err_clr", 32'(mem_error), 0);
    chk("rmw_stall_clr", 32'(stall_cycles), 0);

    // Saturation of both counters (CNT_W=4 -> 15)
    set_lu(5'd5, 5'd5, 5'd0);
    repeat (20) tick();
    clear_inputs(); #1;
    chk("sat_stall", 32'(stall_cycles), 15);
    exmem_jump = 1'b1;
    repeat (20) tick();
    clear_inputs(); #1;
    chk("sat_flush", 32'(flush_count), 15);
    chk("sat_stall_hold", 32'(stall_cycles), 15);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
